// File: rtl/audio_pkg.sv
// Shared types and constants for the audio frame scheduler.
// Mode encodings, FSM states and datapath limits live here.
package audio_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_MUTE = 2'd1,
    MODE_TONE = 2'd2,
    MODE_GAIN = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL_L  = 2'd1,
    MUL_R  = 2'd2,
    COMMIT = 2'd3
  } state_e;

  localparam logic signed [19:0] TONE_AMP = 20'sh08000;
  localparam logic signed [19:0] SAT_MAX_DEF = 20'sh7FFFF;
  localparam logic signed [19:0] SAT_MIN_DEF = -SAT_MAX_DEF - 20'sd1;

  typedef struct packed {
    logic signed [19:0] l;
    logic signed [19:0] r;
    mode_e              mode;
    logic [7:0]         gain;
    logic [10:0]        half;
  } frame_t;

endpackage

// File: rtl/audio_frame_scheduler_gain_mult.sv
// Shared gain multiplier: registered product, then shift and clamp.
// The product register gives exactly one cycle of latency.
module gain_mult
  import audio_pkg::*;
#(
  parameter logic signed [19:0] SAT_MAX = SAT_MAX_DEF
) (
  input  logic               clk,
  input  logic signed [19:0] sample_i,
  input  logic [7:0]         gain_i,
  output logic signed [19:0] res_o
);

  localparam logic signed [28:0] HI = 29'(SAT_MAX);
  localparam logic signed [28:0] LO = -HI - 29'sd1;

  logic signed [28:0] prod_q;
  logic signed [28:0] shr;
  logic signed [28:0] samp_x;
  logic signed [28:0] gain_x;

  assign samp_x = 29'(sample_i);
  assign gain_x = $signed(29'({1'b0, gain_i}));

  always_ff @(posedge clk) begin
    prod_q <= samp_x * gain_x;
  end

  assign shr = prod_q >>> 7;

  always_comb begin
    res_o = shr[19:0];
    if (shr > HI) begin
      res_o = HI[19:0];
    end else if (shr < LO) begin
      res_o = LO[19:0];
    end
  end

endmodule

// File: rtl/audio_frame_scheduler.sv
// Per-frame audio processor: sync AC'97 ready, run a 4-state
// FSM over a shared multiplier, commit both channels together.
module audio_frame_scheduler
  import audio_pkg::*;
#(
  parameter int               FRAMES_PER_TOGGLE = 24000,
  parameter logic signed [19:0] SAT_MAX = SAT_MAX_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ready,
  input  logic signed [19:0] left_in,
  input  logic signed [19:0] right_in,
  input  logic [1:0]         mode,
  input  logic [7:0]         gain,
  input  logic [10:0]        tone_half,
  output logic signed [19:0] left_out,
  output logic signed [19:0] right_out,
  output logic               frame_done,
  output logic               overrun,
  output logic               LED
);

  localparam int LW = (FRAMES_PER_TOGGLE > 1) ?
                      $clog2(FRAMES_PER_TOGGLE) : 1;
  localparam logic [LW-1:0] LMAX = LW'(FRAMES_PER_TOGGLE - 1);

  logic               sync1_q, sync2_q, sync3_q;
  logic [1:0]         fill_q;
  logic               armed_q;
  logic               strobe;

  state_e             state_q, state_d;
  frame_t             frm_q, frm_d;
  logic signed [19:0] lres_q, lres_d;
  logic signed [19:0] lout_q, lout_d;
  logic signed [19:0] rout_q, rout_d;
  logic               done_q, done_d;
  logic               ovr_q, ovr_d;
  logic               led_q, led_d;
  logic [10:0]        tcnt_q, tcnt_d;
  logic               phase_q, phase_d;
  logic [LW-1:0]      lcnt_q, lcnt_d;

  logic signed [19:0] mop;
  logic signed [19:0] mres;
  logic signed [19:0] tone;
  logic [10:0]        tlim;

  // Arming waits until the sync chain holds a real sample of
  // ready that is low, so a level held through reset is no edge.
  assign strobe = sync2_q & ~sync3_q & armed_q;

  assign mop  = (state_q == MUL_L) ? frm_q.l : frm_q.r;
  assign tone = phase_q ? TONE_AMP : -TONE_AMP;
  assign tlim = (frm_q.half == 11'd0) ? 11'd0 :
                frm_q.half - 11'd1;

  gain_mult #(
    .SAT_MAX (SAT_MAX)
  ) u_mult (
    .clk      (clock),
    .sample_i (mop),
    .gain_i   (frm_q.gain),
    .res_o    (mres)
  );

  always_comb begin
    state_d = state_q;
    frm_d   = frm_q;
    lres_d  = lres_q;
    lout_d  = lout_q;
    rout_d  = rout_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;
    led_d   = led_q;
    tcnt_d  = tcnt_q;
    phase_d = phase_q;
    lcnt_d  = lcnt_q;
    if (strobe && state_q != IDLE) begin
      ovr_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (strobe) begin
          state_d    = MUL_L;
          frm_d.l    = left_in;
          frm_d.r    = right_in;
          frm_d.mode = mode_e'(mode);
          frm_d.gain = gain;
          frm_d.half = tone_half;
        end
      end
      MUL_L: begin
        state_d = MUL_R;
      end
      MUL_R: begin
        state_d = COMMIT;
        lres_d  = mres;
      end
      COMMIT: begin
        state_d = IDLE;
        done_d  = 1'b1;
        unique case (frm_q.mode)
          MODE_PASS: begin
            lout_d = frm_q.l;
            rout_d = frm_q.r;
          end
          MODE_MUTE: begin
            lout_d = '0;
            rout_d = '0;
          end
          MODE_TONE: begin
            lout_d = tone;
            rout_d = tone;
          end
          MODE_GAIN: begin
            lout_d = lres_q;
            rout_d = mres;
          end
        endcase
        if (tcnt_q < tlim) begin
          tcnt_d = tcnt_q + 11'd1;
        end else begin
          tcnt_d  = '0;
          phase_d = ~phase_q;
        end
        if (lcnt_q == LMAX) begin
          lcnt_d = '0;
          led_d  = ~led_q;
        end else begin
          lcnt_d = lcnt_q + LW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      fill_q  <= '0;
      armed_q <= 1'b0;
      state_q <= IDLE;
      frm_q   <= '0;
      lres_q  <= '0;
      lout_q  <= '0;
      rout_q  <= '0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      led_q   <= 1'b0;
      tcnt_q  <= '0;
      phase_q <= 1'b0;
      lcnt_q  <= '0;
    end else begin
      sync1_q <= ready;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      fill_q  <= {fill_q[0], 1'b1};
      armed_q <= armed_q | (fill_q[1] & ~sync2_q);
      state_q <= state_d;
      frm_q   <= frm_d;
      lres_q  <= lres_d;
      lout_q  <= lout_d;
      rout_q  <= rout_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
      led_q   <= led_d;
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
      lcnt_q  <= lcnt_d;
    end
  end

  assign left_out   = lout_q;
  assign right_out  = rout_q;
  assign frame_done = done_q;
  assign overrun    = ovr_q;
  assign LED        = led_q;

endmodule

// File: tb/tb_audio_frame_scheduler.sv
// Directed bench for audio_frame_scheduler.
// Each task drives one scenario and checks inline.
module tb_audio_frame_scheduler;

  logic               clk = 1'b0;
  logic               reset;
  logic               ready;
  logic signed [19:0] left_in, right_in;
  logic [1:0]         mode;
  logic [7:0]         gain;
  logic [10:0]        tone_half;
  logic signed [19:0] left_out, right_out;
  logic               frame_done, overrun, LED;

  int tests = 0;
  int fails = 0;

  localparam logic [19:0] TP = 20'h08000;
  localparam logic [19:0] TN = 20'hF8000;

  audio_frame_scheduler #(
    .FRAMES_PER_TOGGLE (4)
  ) dut (
    .clock      (clk),
    .reset      (reset),
    .ready      (ready),
    .left_in    (left_in),
    .right_in   (right_in),
    .mode       (mode),
    .gain       (gain),
    .tone_half  (tone_half),
    .left_out   (left_out),
    .right_out  (right_out),
    .frame_done (frame_done),
    .overrun    (overrun),
    .LED        (LED)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  // Raises ready once; scrambles inputs after they are latched.
  task automatic send_frame(
    input  logic [19:0] l,
    input  logic [19:0] r,
    input  logic [1:0]  m,
    input  logic [7:0]  g,
    input  logic [10:0] th,
    output int          first,
    output int          pulses
  );
    @(negedge clk);
    left_in = l; right_in = r; mode = m;
    gain = g; tone_half = th; ready = 1'b1;
    first = 0;
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) begin
        left_in = ~l; right_in = ~r; mode = ~m;
        gain = ~g; tone_half = ~th;
      end
      if (frame_done) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
    @(negedge clk);
    ready = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if (left_out !== 20'h0 || right_out !== 20'h0) begin
      fails++;
      $display("FAIL reset_out got %h/%h want 0/0",
               left_out, right_out);
    end
    tests++;
    if (frame_done !== 1'b0 || overrun !== 1'b0 ||
        LED !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags got %b%b%b want 000",
               frame_done, overrun, LED);
    end
  endtask

  task automatic test_passthrough();
    int f, p;
    do_reset();
    send_frame(20'h12345, 20'hFEDCB, 2'd0, 8'd0, 11'd0, f, p);
    tests++;
    if (f != 6) begin
      fails++;
      $display("FAIL pass_latency got %0d want 6", f);
    end
    tests++;
    if (p != 1) begin
      fails++;
      $display("FAIL pass_pulses got %0d want 1", p);
    end
    tests++;
    if (left_out !== 20'h12345 || right_out !== 20'hFEDCB) begin
      fails++;
      $display("FAIL pass_data got %h/%h want 12345/fedcb",
               left_out, right_out);
    end
  endtask

  task automatic test_gain();
    int f, p;
    logic [19:0] vec [4][6];
    vec[0] = '{20'h10000, 20'hFFF00, 20'd64,
               20'h08000, 20'hFFF80, 20'd0};
    vec[1] = '{20'h7FFFF, 20'h00080, 20'd255,
               20'h7FFFF, 20'h000FF, 20'd0};
    vec[2] = '{20'h00100, 20'h80000, 20'd200,
               20'h00190, 20'h80000, 20'd0};
    vec[3] = '{20'hFFFFD, 20'h00005, 20'd1,
               20'hFFFFF, 20'h00000, 20'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send_frame(vec[i][0], vec[i][1], 2'd3, vec[i][2][7:0],
                 11'd0, f, p);
      tests++;
      if (left_out !== vec[i][3] || right_out !== vec[i][4] ||
          f != 6) begin
        fails++;
        $display("FAIL gain_%0d got %h/%h@%0d want %h/%h@6",
                 i, left_out, right_out, f, vec[i][3], vec[i][4]);
      end
    end
  endtask

  task automatic test_tone();
    int f, p;
    logic [19:0] exp;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      send_frame(20'h1, 20'h2, 2'd2, 8'd0, 11'd3, f, p);
      exp = ((i / 3) % 2 == 0) ? TN : TP;
      tests++;
      if (left_out !== exp || right_out !== exp) begin
        fails++;
        $display("FAIL tone3_%0d got %h/%h want %h",
                 i, left_out, right_out, exp);
      end
    end
    for (int i = 0; i < 4; i++) begin
      send_frame(20'h1, 20'h2, 2'd2, 8'd0, 11'd0, f, p);
      exp = (i % 2 == 0) ? TN : TP;
      tests++;
      if (left_out !== exp || right_out !== exp) begin
        fails++;
        $display("FAIL tone0_%0d got %h/%h want %h",
                 i, left_out, right_out, exp);
      end
    end
  endtask

  task automatic test_overrun();
    int p;
    int f;
    int q;
    do_reset();
    @(negedge clk);
    left_in = 20'h00ABC; right_in = 20'h00DEF;
    mode = 2'd0; gain = 8'd0; tone_half = 11'd0;
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    ready = 1'b1;
    p = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (frame_done) p++;
    end
    tests++;
    if (p != 1) begin
      fails++;
      $display("FAIL ovr_pulses got %0d want 1", p);
    end
    tests++;
    if (overrun !== 1'b1 || left_out !== 20'h00ABC) begin
      fails++;
      $display("FAIL ovr_flag got %b/%h want 1/00abc",
               overrun, left_out);
    end
    @(negedge clk);
    ready = 1'b0;
    repeat (3) @(posedge clk);
    send_frame(20'h3, 20'h4, 2'd0, 8'd0, 11'd0, f, q);
    tests++;
    if (overrun !== 1'b1 || q != 1) begin
      fails++;
      $display("FAIL ovr_sticky got %b/%0d want 1/1",
               overrun, q);
    end
    do_reset();
    #1;
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL ovr_clear got %b want 0", overrun);
    end
  endtask

  task automatic test_reset_mid();
    int f, p;
    do_reset();
    send_frame(20'h11111, 20'h22222, 2'd0, 8'd0, 11'd0, f, p);
    @(negedge clk);
    left_in = 20'h33333; right_in = 20'h44444;
    mode = 2'd0;
    ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    p = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) reset = 1'b0;
      if (frame_done) p++;
    end
    tests++;
    if (p != 0) begin
      fails++;
      $display("FAIL mid_pulses got %0d want 0", p);
    end
    tests++;
    if (left_out !== 20'h0 || right_out !== 20'h0 ||
        overrun !== 1'b0) begin
      fails++;
      $display("FAIL mid_state got %h/%h/%b want 0/0/0",
               left_out, right_out, overrun);
    end
    @(negedge clk);
    ready = 1'b0;
    repeat (4) @(posedge clk);
    send_frame(20'h55555, 20'h66666, 2'd0, 8'd0, 11'd0, f, p);
    tests++;
    if (left_out !== 20'h55555 || right_out !== 20'h66666 ||
        f != 6 || p != 1) begin
      fails++;
      $display("FAIL mid_next got %h/%h@%0d x%0d want 55555/66666@6 x1",
               left_out, right_out, f, p);
    end
  endtask

  task automatic test_heartbeat();
    int f, p;
    logic exp;
    do_reset();
    for (int i = 1; i <= 8; i++) begin
      send_frame(20'h7, 20'h8, 2'd1, 8'd0, 11'd0, f, p);
      exp = (i >= 4 && i < 8);
      tests++;
      if (LED !== exp || left_out !== 20'h0) begin
        fails++;
        $display("FAIL led_%0d got %b/%h want %b/0",
                 i, LED, left_out, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ready = 1'b0;
    left_in = '0; right_in = '0;
    mode = '0; gain = '0; tone_half = '0;
    test_reset();
    test_passthrough();
    test_gain();
    test_tone();
    test_overrun();
    test_reset_mid();
    test_heartbeat();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
